ieeedrv_sd_arb: RTL and testbench
=================================

Name: ieeedrv_sd_arb

Overview:
- Arbitrates the per-subdrive SD block requests (sd_lba/sd_blk_cnt/sd_rd/sd_wr/sd_ack/sd_buff_din) from all IEEE drive units onto one MiSTer SD host channel.
- Sits directly downstream of the drive units' SD request ports and upstream of the hps_io SD interface.
- Round-robin grant, one transfer at a time.
- Lets several units, each with 2 subdrives, share a single image slot channel without losing or interleaving transfers.

Parameters:
- NREQ, 4, number of requesters; the flattened subdrive ports of all units.
- TMO_W, 24, width of the issue-timeout counter; timeout is 2^TMO_W-1 clk_sys cycles.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_lba  in  32 x NREQ  requested LBA per requester
- req_blk_cnt  in  6 x NREQ  block count minus 1 per requester
- req_rd  in  NREQ  read request level
- req_wr  in  NREQ  write request level
- req_ack  out  NREQ  per-requester sd_ack
- req_buff_din  in  8 x NREQ  write data from each requester
- sd_lba  out  32  host LBA
- sd_blk_cnt  out  6  host block count
- sd_rd  out  1  host read strobe (level)
- sd_wr  out  1  host write strobe (level)
- sd_ack  in  1  host acknowledge; high for the whole transfer
- sd_buff_din  out  8  write data muxed from the granted requester
- busy  out  1  a transfer is pending or active
- timeout  out  1  one-cycle pulse when an issue is abandoned

Behaviour:
- Reset (async): state IDLE, grant 0, last 0, all outputs 0.
- FSM states:
  - IDLE
  - ISSUE
  - XFER
  - DONE
- IDLE:
  - Requires sd_ack low and at least one req_rd|req_wr set.
  - Picks the first requester at index last+1, last+2, ... modulo NREQ (wrap at NREQ-1 -> 0).
  - Latches grant, lba, blk_cnt, and op; rd has priority when rd and wr are both set.
  - Next state ISSUE.
  - While sd_ack is high in IDLE (e.g. after reset mid-transfer), nothing is issued.
- ISSUE:
  - sd_rd or sd_wr is driven from the latched op; sd_lba/sd_blk_cnt come from the latched values.
  - sd_ack rising -> XFER.
  - The timeout counter increments each cycle.
  - At all-ones: timeout pulse, strobes drop, last <= grant, -> IDLE.
- XFER:
  - Strobes stay asserted until sd_ack falls, matching host semantics.
  - sd_ack falling -> DONE.
- DONE:
  - One cycle; strobes low; last <= grant.
  - -> IDLE, so there is a 1-cycle gap between transfers.
- req_ack[g] = sd_ack & (state is ISSUE or XFER) & (grant==g). This is combinational so it stays aligned with sd_buff_wr. All other req_ack bits are 0.
- sd_buff_din = req_buff_din[grant] combinationally, in every state.
- Request handling:
  - Requester inputs are sampled only in IDLE.
  - Deasserting a request after grant does not abort; the transfer completes.
  - A request still asserted after DONE re-arbitrates normally. Requesters must drop their strobe on seeing req_ack.
  - The non-priority op of a requester with both rd and wr set is served on a later grant.
- busy = (state != IDLE) | (|req_rd) | (|req_wr).
- Latched lba/blk_cnt are stable from ISSUE through DONE, regardless of requester input changes.
- Grant index width: $clog2(NREQ), minimum 1.
- NREQ=1 degenerates to pass-through with the FSM still present.

Decomposition:
- Shared package ieeedrv_pkg gets:
  - typedef sd_arb_state_t {IDLE, ISSUE, XFER, DONE}
  - localparam SD_BLK_W=6
  - localparam SD_LBA_W=32
- One sub-module, ieeedrv_rr_pick: combinational round-robin priority encoder (request vector, last index -> valid, index).

Test Plan:
- Single read:
  - Stimulus: req_rd[2]=1, lba 357, blk_cnt 0. Host raises sd_ack 3 cycles after sd_rd and holds it 256 cycles.
  - Required: sd_lba=357, sd_rd=1 until sd_ack falls; req_ack[2] mirrors sd_ack; req_ack[0,1,3]=0; one DONE cycle, then IDLE.
- Round-robin fairness:
  - Stimulus: last=0, all four requesting rd, each drops on its ack.
  - Required: grant order 1,2,3,0; one-cycle gap between transfers.
- rd/wr priority plus write data routing:
  - Stimulus: requester 1 sets rd and wr together; its req_buff_din=A5.
  - Required: read served first. The write is granted next turn, with sd_wr=1 and sd_buff_din=A5 throughout XFER.
- Timeout:
  - Stimulus: TMO_W=4, sd_ack never rises.
  - Required: after 15 ISSUE cycles, timeout pulses for 1 cycle, sd_rd drops, state IDLE, next requester served.
- Reset mid-XFER:
  - Stimulus: assert reset while sd_ack=1 and the request is still pending.
  - Required: all outputs 0 immediately (async). After release, no strobe until sd_ack low; then a fresh grant.
- Request withdrawn after grant:
  - Stimulus: req_wr[3] drops 1 cycle into ISSUE.
  - Required: sd_wr is held and the transfer completes through DONE with the latched lba unchanged.

Source files
------------

// File: rtl/ieeedrv_sd_arb_pkg.sv
// ieeedrv_pkg: shared types and widths for the IEEE drive SD request path
package ieeedrv_pkg;
    localparam int SD_BLK_W = 6;
    localparam int SD_LBA_W = 32;
    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} sd_arb_state_t;
endpackage

// File: rtl/ieeedrv_sd_arb_if.sv
// ieeedrv_sd_arb_if: one MiSTer SD host channel (arbiter is master, hps_io side is slave)
interface ieeedrv_sd_arb_if;
    import ieeedrv_pkg::*;
    logic [SD_LBA_W-1:0] lba;
    logic [SD_BLK_W-1:0] blk_cnt;
    logic                rd;
    logic                wr;
    logic                ack;
    logic [7:0]          buff_din;
    modport master (output lba, blk_cnt, rd, wr, buff_din, input ack);
    modport slave (input lba, blk_cnt, rd, wr, buff_din, output ack);
endinterface

// File: rtl/ieeedrv_rr_pick.sv
// ieeedrv_rr_pick: round-robin priority encoder, first request after index last
module ieeedrv_rr_pick
    import ieeedrv_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int GW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   last,
    output logic            valid,
    output logic [GW-1:0]   idx
);
    // scan from farthest to nearest so the nearest request after last wins
    always_comb begin
        valid = |req;
        idx = '0;
        for (int k = NREQ; k >= 1; k--)
            if (req[(int'(last) + k) % NREQ]) idx = GW'((int'(last) + k) % NREQ);
    end
endmodule

// File: rtl/ieeedrv_sd_arb.sv
// ieeedrv_sd_arb: round-robin arbiter of subdrive SD requests onto one host SD channel
module ieeedrv_sd_arb
    import ieeedrv_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TMO_W = 24
) (
    input  logic                               clk_sys,
    input  logic                               reset,
    input  logic [NREQ-1:0][SD_LBA_W-1:0]      req_lba,
    input  logic [NREQ-1:0][SD_BLK_W-1:0]      req_blk_cnt,
    input  logic [NREQ-1:0]                    req_rd,
    input  logic [NREQ-1:0]                    req_wr,
    output logic [NREQ-1:0]                    req_ack,
    input  logic [NREQ-1:0][7:0]               req_buff_din,
    ieeedrv_sd_arb_if.master                   sd,
    output logic                               busy,
    output logic                               timeout
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sd_arb_state_t state;
    logic [GW-1:0] grant, last, pick_idx;
    logic          pick_valid;
    logic [TMO_W-1:0] cnt, cnt_nxt;

    ieeedrv_rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
        .req   (req_rd | req_wr),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign cnt_nxt = cnt + TMO_W'(1);
    assign sd.buff_din = req_buff_din[grant];
    assign busy = (state != IDLE) | (|req_rd) | (|req_wr);

    // ack is steered combinationally so it lines up with the host's buffer write strobe
    always_comb begin
        req_ack = '0;
        req_ack[grant] = sd.ack & ((state == ISSUE) | (state == XFER));
    end

    // arbitration FSM; a stale ack left over from a reset blocks new issues
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            last <= '0;
            cnt <= '0;
            sd.lba <= '0;
            sd.blk_cnt <= '0;
            sd.rd <= 1'b0;
            sd.wr <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!sd.ack && pick_valid) begin
                        grant <= pick_idx;
                        sd.lba <= req_lba[pick_idx];
                        sd.blk_cnt <= req_blk_cnt[pick_idx];
                        sd.rd <= req_rd[pick_idx];
                        sd.wr <= !req_rd[pick_idx];
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sd.ack) begin
                        state <= XFER;
                    end else if (&cnt_nxt) begin
                        timeout <= 1'b1;
                        sd.rd <= 1'b0;
                        sd.wr <= 1'b0;
                        last <= grant;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                XFER: begin
                    if (!sd.ack) begin
                        sd.rd <= 1'b0;
                        sd.wr <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    last <= grant;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ieeedrv_sd_arb.sv
// tb_ieeedrv_sd_arb: scenario and randomized checks of the SD arbiter against a rule-level model
module tb_ieeedrv_sd_arb;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0][31:0] req_lba = '0;
    logic [N-1:0][5:0]  req_blk_cnt = '0;
    logic [N-1:0]       req_rd = '0;
    logic [N-1:0]       req_wr = '0;
    logic [N-1:0]       req_ack;
    logic [N-1:0][7:0]  req_buff_din = '0;
    logic               busy, timeout;
    int n_cmp = 0;
    int n_err = 0;
    int m_last = 0;

    ieeedrv_sd_arb_if sd_if ();

    ieeedrv_sd_arb #(.NREQ(N), .TMO_W(4)) dut (
        .clk_sys      (clk),
        .reset        (reset),
        .req_lba      (req_lba),
        .req_blk_cnt  (req_blk_cnt),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_ack      (req_ack),
        .req_buff_din (req_buff_din),
        .sd           (sd_if),
        .busy         (busy),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    function automatic int exp_grant(input int last);
        for (int k = 1; k <= N; k++)
            if (req_rd[(last + k) % N] | req_wr[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // host agent: waits for a strobe, acks after dly cycles for hold cycles, requester drops its op on ack
    task automatic host_xfer(input int dly, input int hold, input int wd,
                             output bit seen, output int idle_n, output int g, output bit rd_op,
                             output logic [31:0] lba, output logic [5:0] blk, output logic [7:0] din,
                             output bit ok);
        seen = 0; idle_n = 0; g = -1; rd_op = 0; lba = '0; blk = '0; din = '0; ok = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sd_if.rd | sd_if.wr) begin seen = 1; break; end
            idle_n++;
        end
        if (!seen) return;
        rd_op = sd_if.rd; lba = sd_if.lba; blk = sd_if.blk_cnt;
        for (int i = 0; i < dly; i++) begin
            if (wd >= 0 && i == 0) begin req_rd[wd] = 0; req_wr[wd] = 0; req_lba[wd] = $urandom; end
            @(negedge clk);
            if (sd_if.rd !== rd_op || sd_if.wr !== !rd_op || sd_if.lba !== lba || sd_if.blk_cnt !== blk
                || req_ack !== '0 || busy !== 1'b1) ok = 0;
        end
        sd_if.ack = 1'b1;
        for (int i = 0; i < hold; i++) begin
            #1;
            if (i == 0) begin
                for (int j = 0; j < N; j++) if (req_ack[j]) g = j;
                din = sd_if.buff_din;
                if (g >= 0) begin if (rd_op) req_rd[g] = 0; else req_wr[g] = 0; end
            end
            if (g < 0 || req_ack !== (4'b0001 << g) || sd_if.rd !== rd_op || sd_if.wr !== !rd_op
                || sd_if.lba !== lba || sd_if.blk_cnt !== blk || sd_if.buff_din !== din || busy !== 1'b1) ok = 0;
            @(negedge clk);
        end
        sd_if.ack = 1'b0;
        #1;
        if (req_ack !== '0) ok = 0;
        @(negedge clk);
        if (sd_if.rd !== 1'b0 || sd_if.wr !== 1'b0 || req_ack !== '0 || busy !== 1'b1) ok = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sd_if.ack = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({sd_if.rd, sd_if.wr, sd_if.lba, sd_if.blk_cnt} !== '0) begin n_err++;
            $display("FAIL reset_outputs: got rd=%b wr=%b lba=%0d blk=%0d want all 0", sd_if.rd, sd_if.wr, sd_if.lba, sd_if.blk_cnt); end
        n_cmp++; if ({req_ack, busy, timeout} !== '0) begin n_err++;
            $display("FAIL reset_flags: got ack=%b busy=%b tmo=%b want 0", req_ack, busy, timeout); end
        reset = 1'b0;
        m_last = 0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_read();
        bit seen, rd_op, ok; int idle_n, g; logic [31:0] lba; logic [5:0] blk; logic [7:0] din;
        req_lba[2] = 357; req_blk_cnt[2] = 0; req_rd[2] = 1;
        host_xfer(3, 256, -1, seen, idle_n, g, rd_op, lba, blk, din, ok);
        n_cmp++; if (!seen || g !== 2 || rd_op !== 1'b1) begin n_err++;
            $display("FAIL single_grant: got seen=%b g=%0d rd=%b want 1 2 1", seen, g, rd_op); end
        n_cmp++; if (lba !== 32'd357 || blk !== 6'd0) begin n_err++;
            $display("FAIL single_lba: got lba=%0d blk=%0d want 357 0", lba, blk); end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL single_protocol: got ok=0 want 1"); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || sd_if.rd !== 1'b0) begin n_err++;
            $display("FAIL single_idle: got busy=%b rd=%b want 0 0", busy, sd_if.rd); end
        m_last = 2;
    endtask

    task automatic test_round_robin();
        bit seen, rd_op, ok; int idle_n, g, eg; logic [31:0] lba; logic [5:0] blk; logic [7:0] din;
        req_lba[0] = 32'h1000; req_rd[0] = 1;
        host_xfer(1, 2, -1, seen, idle_n, g, rd_op, lba, blk, din, ok);
        n_cmp++; if (!seen || g !== 0 || !ok) begin n_err++;
            $display("FAIL rr_prelude: got seen=%b g=%0d ok=%b want 1 0 1", seen, g, ok); end
        m_last = 0;
        for (int i = 0; i < N; i++) begin req_lba[i] = 32'h100 + i; req_blk_cnt[i] = 6'(i + 1); req_rd[i] = 1; end
        for (int t = 0; t < N; t++) begin
            eg = (t + 1) % N;
            host_xfer(2, 3, -1, seen, idle_n, g, rd_op, lba, blk, din, ok);
            n_cmp++; if (!seen || g !== eg || lba !== 32'h100 + eg || blk !== 6'(eg + 1) || !ok) begin n_err++;
                $display("FAIL rr_order%0d: got g=%0d lba=%h ok=%b want g=%0d lba=%h", t, g, lba, ok, eg, 32'h100 + eg); end
            if (t > 0) begin
                n_cmp++; if (idle_n !== 1) begin n_err++; $display("FAIL rr_gap%0d: got idle=%0d want 1", t, idle_n); end
            end
        end
        m_last = 0;
    endtask

    task automatic test_rdwr_priority();
        bit seen, rd_op, ok; int idle_n, g; logic [31:0] lba; logic [5:0] blk; logic [7:0] din;
        req_lba[1] = 32'hCAFE; req_buff_din[1] = 8'hA5; req_buff_din[0] = 8'h3C; req_rd[1] = 1; req_wr[1] = 1;
        host_xfer(1, 4, -1, seen, idle_n, g, rd_op, lba, blk, din, ok);
        n_cmp++; if (!seen || g !== 1 || rd_op !== 1'b1 || !ok) begin n_err++;
            $display("FAIL prio_rd_first: got g=%0d rd=%b ok=%b want 1 1 1", g, rd_op, ok); end
        host_xfer(2, 6, -1, seen, idle_n, g, rd_op, lba, blk, din, ok);
        n_cmp++; if (!seen || g !== 1 || rd_op !== 1'b0 || !ok) begin n_err++;
            $display("FAIL prio_wr_next: got g=%0d rd=%b ok=%b want 1 0 1", g, rd_op, ok); end
        n_cmp++; if (din !== 8'hA5 || lba !== 32'hCAFE) begin n_err++;
            $display("FAIL prio_wr_data: got din=%h lba=%h want a5 cafe", din, lba); end
        m_last = 1;
    endtask

    task automatic test_timeout();
        bit seen, rd_op, ok; int idle_n, g, hi; logic [31:0] lba; logic [5:0] blk; logic [7:0] din;
        req_lba[2] = 32'h22; req_lba[3] = 32'h33; req_rd[2] = 1; req_rd[3] = 1;
        hi = 0;
        for (int i = 0; i < 100 && !(sd_if.rd | sd_if.wr); i++) @(negedge clk);
        n_cmp++; if (sd_if.lba !== 32'h22 || sd_if.rd !== 1'b1) begin n_err++;
            $display("FAIL tmo_issue: got lba=%h rd=%b want 22 1", sd_if.lba, sd_if.rd); end
        for (int i = 0; i < 40 && sd_if.rd; i++) begin hi++; @(negedge clk); end
        n_cmp++; if (hi !== 15) begin n_err++; $display("FAIL tmo_cycles: got %0d want 15", hi); end
        n_cmp++; if (timeout !== 1'b1 || sd_if.rd !== 1'b0) begin n_err++;
            $display("FAIL tmo_pulse: got tmo=%b rd=%b want 1 0", timeout, sd_if.rd); end
        @(negedge clk);
        n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL tmo_width: got %b want 0", timeout); end
        host_xfer(1, 2, -1, seen, idle_n, g, rd_op, lba, blk, din, ok);
        n_cmp++; if (!seen || g !== 3 || lba !== 32'h33 || !ok) begin n_err++;
            $display("FAIL tmo_next: got g=%0d lba=%h ok=%b want 3 33 1", g, lba, ok); end
        host_xfer(1, 2, -1, seen, idle_n, g, rd_op, lba, blk, din, ok);
        n_cmp++; if (!seen || g !== 2 || !ok) begin n_err++;
            $display("FAIL tmo_retry: got g=%0d ok=%b want 2 1", g, ok); end
        m_last = 2;
    endtask

    task automatic test_reset_mid_xfer();
        bit seen, rd_op, ok, strobe; int idle_n, g; logic [31:0] lba; logic [5:0] blk; logic [7:0] din;
        req_lba[0] = 32'h77; req_blk_cnt[0] = 6'd9; req_rd[0] = 1;
        for (int i = 0; i < 100 && !(sd_if.rd | sd_if.wr); i++) @(negedge clk);
        sd_if.ack = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({sd_if.rd, sd_if.wr, sd_if.lba, sd_if.blk_cnt, req_ack, timeout} !== '0) begin n_err++;
            $display("FAIL rst_async: got rd=%b lba=%h ack=%b want 0", sd_if.rd, sd_if.lba, req_ack); end
        @(negedge clk);
        reset = 1'b0;
        m_last = 0;
        strobe = 0;
        repeat (5) begin @(negedge clk); if (sd_if.rd | sd_if.wr) strobe = 1; end
        n_cmp++; if (strobe !== 1'b0) begin n_err++; $display("FAIL rst_stale_ack: got strobe=1 want 0"); end
        sd_if.ack = 1'b0;
        host_xfer(1, 3, -1, seen, idle_n, g, rd_op, lba, blk, din, ok);
        n_cmp++; if (!seen || g !== 0 || lba !== 32'h77 || blk !== 6'd9 || !ok) begin n_err++;
            $display("FAIL rst_regrant: got g=%0d lba=%h blk=%0d ok=%b want 0 77 9 1", g, lba, blk, ok); end
        m_last = 0;
    endtask

    task automatic test_withdraw();
        bit seen, rd_op, ok; int idle_n, g; logic [31:0] lba; logic [5:0] blk; logic [7:0] din;
        req_lba[3] = 32'hDEAD0003; req_blk_cnt[3] = 6'd5; req_wr[3] = 1;
        host_xfer(3, 5, 3, seen, idle_n, g, rd_op, lba, blk, din, ok);
        n_cmp++; if (!seen || g !== 3 || rd_op !== 1'b0 || !ok) begin n_err++;
            $display("FAIL wd_complete: got g=%0d rd=%b ok=%b want 3 0 1", g, rd_op, ok); end
        n_cmp++; if (lba !== 32'hDEAD0003 || blk !== 6'd5) begin n_err++;
            $display("FAIL wd_lba: got lba=%h blk=%0d want dead0003 5", lba, blk); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wd_idle: got busy=%b want 0", busy); end
        m_last = 3;
    endtask

    task automatic test_random();
        bit seen, rd_op, ok; int idle_n, g, eg; logic [31:0] lba; logic [5:0] blk; logic [7:0] din;
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < N; i++)
                if (!(req_rd[i] | req_wr[i]) && ($urandom_range(1, 0) == 1 || it % 5 == 0)) begin
                    int op = $urandom_range(3, 1);
                    req_rd[i] = op[0]; req_wr[i] = op[1];
                    req_lba[i] = $urandom; req_blk_cnt[i] = 6'($urandom); req_buff_din[i] = 8'($urandom);
                end
            if (!(|(req_rd | req_wr))) begin req_rd[it % N] = 1; req_lba[it % N] = $urandom; end
            eg = exp_grant(m_last);
            host_xfer($urandom_range(4, 0), $urandom_range(6, 1), -1, seen, idle_n, g, rd_op, lba, blk, din, ok);
            n_cmp++;
            if (!seen || g !== eg || rd_op !== req_rd[eg] && rd_op !== 1'b1 || lba !== req_lba[eg]
                || blk !== req_blk_cnt[eg] || din !== req_buff_din[eg] || !ok) begin n_err++;
                $display("FAIL rand%0d: got g=%0d lba=%h blk=%0d din=%h ok=%b want g=%0d lba=%h blk=%0d din=%h",
                         it, g, lba, blk, din, ok, eg, req_lba[eg], req_blk_cnt[eg], req_buff_din[eg]); end
            m_last = eg;
        end
    endtask

    initial begin
        sd_if.ack = 1'b0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_rdwr_priority();
        test_timeout();
        test_reset_mid_xfer();
        test_withdraw();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
